dsp_result_uart_tx: RTL and testbench

//  Reader end of the DSP result path. On a start pulse, snapshots N_WORDS product words

---
 rtl/dsp_uart_pkg.sv | 45 ++++
 rtl/uart_tx_byte.sv | 100 ++++++++++
 rtl/dsp_result_uart_tx.sv | 180 ++++++++++++++++++
 tb/tb_dsp_result_uart_tx.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_uart_pkg.sv
// ----------------------------------------------------------------------------
// dsp_uart_pkg
// Shared constants, types and helpers for the DSP result UART path.
//   ASCII_*       : byte values used when formatting product words as hex text
//   BIT_*         : bit-slot indices inside one 8N1 UART character
//   tx_state_e    : top-level frame FSM states
//   char_phase_e  : which part of a line is being sent (hex digits, CR or LF)
//   hex_ascii()   : 4-bit nibble -> uppercase ASCII hex digit
// ----------------------------------------------------------------------------
package dsp_uart_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_A  = 8'h41;

  // Bit slots of one character: 0 = start, 1..8 = data LSB first, 9 = stop.
  localparam logic [3:0] BIT_START     = 4'd0;
  localparam logic [3:0] BIT_LAST_DATA = 4'd8;
  localparam logic [3:0] BIT_STOP      = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_FIN  = 2'd3
  } tx_state_e;

  typedef enum logic [1:0] {
    PH_HEX = 2'd0,
    PH_CR  = 2'd1,
    PH_LF  = 2'd2
  } char_phase_e;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nibble);
    logic [7:0] ch;
    if (nibble < 4'd10) begin
      ch = ASCII_0 + {4'd0, nibble};
    end else begin
      ch = ASCII_A + ({4'd0, nibble} - 8'd10);
    end
    return ch;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// ----------------------------------------------------------------------------
// uart_tx_byte
// 8N1 UART byte transmitter with a valid/ready byte interface.
//   clk    in  : clock, rising edge
//   reset  in  : synchronous, active-high
//   data   in  : byte to send, sampled when valid && ready
//   valid  in  : a byte is offered
//   ready  out : high when idle or in the last cycle of a stop bit
//   tx     out : serial line, idle high, registered
// Holding valid through the stop bit chains the next byte with no idle gap.
// ----------------------------------------------------------------------------
module uart_tx_byte
  import dsp_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 234
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic             active_q, active_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             stop_end_s;

  // The last cycle of a stop bit doubles as the hand-off point for the next byte.
  assign stop_end_s = active_q && (bit_q == BIT_STOP) && (cnt_q == CNT_LAST);
  assign ready      = !active_q || stop_end_s;
  assign tx         = tx_q;

  // Baud counter, bit sequencer and shift register next-state logic.
  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    if (!active_q) begin
      if (valid) begin
        active_d = 1'b1;
        cnt_d    = '0;
        bit_d    = BIT_START;
        shift_d  = data;
        tx_d     = 1'b0;
      end else begin
        tx_d = 1'b1;
      end
    end else if (cnt_q != CNT_LAST) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = '0;
      if (bit_q == BIT_STOP) begin
        if (valid) begin
          // Next start bit begins on the very edge that ends this stop bit.
          bit_d   = BIT_START;
          shift_d = data;
          tx_d    = 1'b0;
        end else begin
          active_d = 1'b0;
          bit_d    = BIT_START;
          tx_d     = 1'b1;
        end
      end else if (bit_q == BIT_LAST_DATA) begin
        bit_d = BIT_STOP;
        tx_d  = 1'b1;
      end else begin
        bit_d   = bit_q + 4'd1;
        tx_d    = shift_q[0];
        shift_d = {1'b0, shift_q[7:1]};
      end
    end
  end

  // State registers with synchronous reset to an idle-high line.
  always_ff @(posedge clk) begin
    if (reset) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      bit_q    <= BIT_START;
      shift_q  <= 8'h00;
      tx_q     <= 1'b1;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
    end
  end

endmodule

// File: rtl/dsp_result_uart_tx.sv
// ----------------------------------------------------------------------------
// dsp_result_uart_tx
// Snapshots N_WORDS product words on a start pulse and streams each word as
// uppercase ASCII hex (MSB nibble first) followed by CR LF over an 8N1 UART.
//   clk       in  : clock, rising edge
//   reset     in  : synchronous, active-high; aborts any frame in flight
//   products  in  : word i = products[i*WORD_W +: WORD_W], word 0 sent first
//   start     in  : frame request, accepted only while busy == 0
//   tx        out : UART serial out, idle high
//   busy      out : high from the accept edge until the frame completes
//   done      out : one-cycle pulse on the edge that ends the last stop bit
// ----------------------------------------------------------------------------
module dsp_result_uart_tx
  import dsp_uart_pkg::*;
#(
  parameter int N_WORDS      = 5,
  parameter int WORD_W       = 64,
  parameter int CLKS_PER_BIT = 234
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_WORDS*WORD_W-1:0]   products,
  input  logic                        start,
  output logic                        tx,
  output logic                        busy,
  output logic                        done
);

  localparam int NIBS  = WORD_W / 4;
  localparam int NIB_W = (NIBS > 1) ? $clog2(NIBS) : 1;
  localparam logic [NIB_W-1:0] NIB_LAST  = NIB_W'(NIBS - 1);
  localparam logic [3:0]       WORD_LAST = 4'(N_WORDS - 1);

  tx_state_e                 state_q, state_d;
  char_phase_e               phase_q, phase_d;
  logic [NIB_W-1:0]          nib_q, nib_d;
  logic [3:0]                word_q, word_d;
  logic [N_WORDS*WORD_W-1:0] snapshot_q, snapshot_d;
  logic [7:0]                char_q, char_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;

  logic [WORD_W-1:0]         word_sel_s;
  logic [3:0]                nibble_s;
  logic [7:0]                char_mux_s;
  logic                      last_char_s;
  logic                      byte_valid_s;
  logic                      byte_ready_s;

  // Character selected by the word/nibble/phase counters.
  always_comb begin
    word_sel_s = snapshot_q[32'(word_q) * WORD_W +: WORD_W];
    nibble_s   = word_sel_s[32'(nib_q) * 32'd4 +: 4];
    case (phase_q)
      PH_HEX:  char_mux_s = hex_ascii(nibble_s);
      PH_CR:   char_mux_s = ASCII_CR;
      PH_LF:   char_mux_s = ASCII_LF;
      default: char_mux_s = ASCII_LF;
    endcase
  end

  assign last_char_s  = (phase_q == PH_LF) && (word_q == WORD_LAST);
  assign byte_valid_s = (state_q == ST_SEND);

  // Frame FSM, counters and snapshot next-state logic.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    nib_d      = nib_q;
    word_d     = word_q;
    snapshot_d = snapshot_q;
    char_d     = char_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          snapshot_d = products;
          phase_d    = PH_HEX;
          nib_d      = NIB_LAST;
          word_d     = 4'd0;
          // The first character comes straight from the live inputs on the
          // accept edge, so the line can drop one cycle later without a LOAD.
          char_d     = hex_ascii(products[WORD_W-1 -: 4]);
          busy_d     = 1'b1;
          state_d    = ST_SEND;
        end else begin
          busy_d = 1'b0;
        end
      end
      ST_LOAD: begin
        char_d  = char_mux_s;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (byte_ready_s) begin
          // Byte handed over: advance the counters to the following character.
          if (last_char_s) begin
            word_d  = 4'd0;
            phase_d = PH_HEX;
            nib_d   = NIB_LAST;
            state_d = ST_FIN;
          end else begin
            case (phase_q)
              PH_HEX: begin
                if (nib_q == '0) begin
                  phase_d = PH_CR;
                end else begin
                  nib_d = nib_q - NIB_W'(1);
                end
              end
              PH_CR: phase_d = PH_LF;
              PH_LF: begin
                phase_d = PH_HEX;
                nib_d   = NIB_LAST;
                word_d  = word_q + 4'd1;
              end
              default: phase_d = PH_HEX;
            endcase
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_FIN: begin
        // Ready here marks the last cycle of the final stop bit.
        if (byte_ready_s) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_FIN;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Frame state registers; reset abandons any frame without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      phase_q    <= PH_HEX;
      nib_q      <= '0;
      word_q     <= 4'd0;
      snapshot_q <= '0;
      char_q     <= 8'h00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      nib_q      <= nib_d;
      word_q     <= word_d;
      snapshot_q <= snapshot_d;
      char_q     <= char_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx_byte (
    .clk   (clk),
    .reset (reset),
    .data  (char_q),
    .valid (byte_valid_s),
    .ready (byte_ready_s),
    .tx    (tx)
  );

endmodule

// File: tb/tb_dsp_result_uart_tx.sv
module tb_dsp_result_uart_tx;

  localparam int CPB      = 4;
  localparam int WW       = 64;
  localparam int BYTE_CYC = 10 * CPB;

  logic          clk     = 1'b0;
  logic          reset   = 1'b1;
  logic [WW-1:0] prod_a  = '0;
  logic          start_a = 1'b0;
  logic          tx_a, busy_a, done_a;
  logic [2*WW-1:0] prod_b = '0;
  logic          start_b = 1'b0;
  logic          tx_b, busy_b, done_b;

  int vec = 0;
  int miss = 0;
  int cyc = 0;
  int done_cnt_a = 0;
  int done_cnt_b = 0;
  int busy_cnt_b = 0;
  logic [7:0] exp_bytes [0:63];

  dsp_result_uart_tx #(.N_WORDS(1), .WORD_W(WW), .CLKS_PER_BIT(CPB)) dut_a (
    .clk(clk), .reset(reset), .products(prod_a), .start(start_a),
    .tx(tx_a), .busy(busy_a), .done(done_a)
  );

  dsp_result_uart_tx #(.N_WORDS(2), .WORD_W(WW), .CLKS_PER_BIT(CPB)) dut_b (
    .clk(clk), .reset(reset), .products(prod_b), .start(start_b),
    .tx(tx_b), .busy(busy_b), .done(done_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done_a === 1'b1) done_cnt_a <= done_cnt_a + 1;
    if (done_b === 1'b1) done_cnt_b <= done_cnt_b + 1;
    if (busy_b === 1'b1) busy_cnt_b <= busy_cnt_b + 1;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation exceeded 80000 cycles");
    $fatal(1, "watchdog");
  end

  function automatic logic tx_of(input bit sel);
    return sel ? tx_b : tx_a;
  endfunction

  function automatic logic done_of(input bit sel);
    return sel ? done_b : done_a;
  endfunction

  function automatic logic [7:0] hexc(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else return 8'h37 + {4'h0, n};
  endfunction

  task automatic fill_word(input int base, input logic [63:0] w);
    for (int i = 0; i < 16; i++) exp_bytes[base + i] = hexc(w[63 - 4 * i -: 4]);
    exp_bytes[base + 16] = 8'h0D;
    exp_bytes[base + 17] = 8'h0A;
  endtask

  task automatic accept(input bit sel, input bit hold, output int acc);
    @(negedge clk);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    acc = cyc;
    if (!hold) begin
      if (sel) start_b = 1'b0; else start_a = 1'b0;
    end
  endtask

  // Receive one byte, sampling each bit in the middle of its CPB-cycle window.
  task automatic rx_byte(input bit sel, output logic [7:0] b, output int t0, output bit ok,
                         output bit timeout);
    int n;
    n = 0;
    ok = 1'b1;
    timeout = 1'b0;
    b = 8'h00;
    t0 = -1;
    while (tx_of(sel) !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      ok = 1'b0;
      timeout = 1'b1;
    end else begin
      t0 = cyc;
      repeat (2) @(negedge clk);
      if (tx_of(sel) !== 1'b0) ok = 1'b0;
      for (int k = 0; k < 8; k++) begin
        repeat (CPB) @(negedge clk);
        b[k] = tx_of(sel);
      end
      repeat (CPB) @(negedge clk);
      if (tx_of(sel) !== 1'b1) ok = 1'b0;
    end
  endtask

  task automatic rx_frame(input bit sel, input int nbytes, input int acc, input bit clr_on_done,
                          input string name);
    logic [7:0] b;
    int t0;
    int k;
    bit ok;
    bit timeout;
    for (int i = 0; i < nbytes; i++) begin
      rx_byte(sel, b, t0, ok, timeout);
      vec++;
      if (!ok || b !== exp_bytes[i]) begin
        miss++;
        $display("FAIL %s byte %0d: got %02h (framing ok=%0d), expected %02h", name, i, b, ok, exp_bytes[i]);
      end
      vec++;
      if (t0 != acc + 1 + BYTE_CYC * i) begin
        miss++;
        $display("FAIL %s start-bit time byte %0d: got cycle %0d, expected %0d", name, i, t0, acc + 1 + BYTE_CYC * i);
      end
      if (timeout) break;
    end
    k = 0;
    while (done_of(sel) !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (clr_on_done) begin
      if (sel) start_b = 1'b0; else start_a = 1'b0;
    end
    vec++;
    if (done_of(sel) !== 1'b1 || cyc != acc + 1 + BYTE_CYC * nbytes) begin
      miss++;
      $display("FAIL %s done time: got cycle %0d (done=%b), expected %0d", name, cyc, done_of(sel), acc + 1 + BYTE_CYC * nbytes);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 6; i++) begin
      if (i == 3) reset = 1'b0;
      @(negedge clk);
      vec++;
      if ({tx_a, busy_a, done_a, tx_b, busy_b, done_b} !== 6'b100_100) begin
        miss++;
        $display("FAIL reset cycle %0d: tx/busy/done a=%b%b%b b=%b%b%b, expected 100 100",
                 i, tx_a, busy_a, done_a, tx_b, busy_b, done_b);
      end
    end
  endtask

  task automatic test_frame_n1();
    int acc;
    int d0;
    logic [7:0] tbl [0:17];
    tbl = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38,
            8'h39, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h0D, 8'h0A};
    for (int i = 0; i < 18; i++) exp_bytes[i] = tbl[i];
    prod_a = 64'h0123456789ABCDEF;
    d0 = done_cnt_a;
    accept(1'b0, 1'b0, acc);
    rx_frame(1'b0, 18, acc, 1'b0, "n1");
    repeat (5) @(negedge clk);
    vec++;
    if (done_cnt_a != d0 + 1 || busy_a !== 1'b0 || tx_a !== 1'b1) begin
      miss++;
      $display("FAIL n1 end: done pulses %0d busy %b tx %b, expected 1 0 1", done_cnt_a - d0, busy_a, tx_a);
    end
  endtask

  task automatic test_frame_n2();
    int acc;
    int b0;
    int d0;
    for (int i = 0; i < 15; i++) exp_bytes[i] = 8'h46;
    exp_bytes[15] = 8'h41;
    exp_bytes[16] = 8'h0D;
    exp_bytes[17] = 8'h0A;
    for (int i = 18; i < 34; i++) exp_bytes[i] = 8'h30;
    exp_bytes[34] = 8'h0D;
    exp_bytes[35] = 8'h0A;
    prod_b = {64'h0000000000000000, 64'hFFFFFFFFFFFFFFFA};
    b0 = busy_cnt_b;
    d0 = done_cnt_b;
    accept(1'b1, 1'b0, acc);
    rx_frame(1'b1, 36, acc, 1'b0, "n2");
    repeat (5) @(negedge clk);
    vec++;
    if (busy_cnt_b - b0 != 1441) begin
      miss++;
      $display("FAIL n2 busy length: got %0d cycles, expected 1441", busy_cnt_b - b0);
    end
    vec++;
    if (done_cnt_b != d0 + 1) begin
      miss++;
      $display("FAIL n2 done count: got %0d, expected 1", done_cnt_b - d0);
    end
  endtask

  task automatic test_snapshot();
    int acc;
    int d0;
    prod_b = {64'h13579BDF2468ACE0, 64'hDEADBEEF00C0FFEE};
    fill_word(0, 64'hDEADBEEF00C0FFEE);
    fill_word(18, 64'h13579BDF2468ACE0);
    d0 = done_cnt_b;
    accept(1'b1, 1'b0, acc);
    fork
      rx_frame(1'b1, 36, acc, 1'b0, "snapshot");
      begin
        repeat (300) @(negedge clk);
        prod_b = ~prod_b;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
      end
    join
    repeat (60) @(negedge clk);
    vec++;
    if (done_cnt_b != d0 + 1 || busy_b !== 1'b0 || tx_b !== 1'b1) begin
      miss++;
      $display("FAIL snapshot end: done pulses %0d busy %b tx %b, expected 1 0 1", done_cnt_b - d0, busy_b, tx_b);
    end
  endtask

  task automatic test_reset_mid();
    int acc;
    int d0;
    bit bad;
    prod_b = {64'h0F1E2D3C4B5A6978, 64'hCAFEF00D8BADBEEF};
    fill_word(0, 64'hCAFEF00D8BADBEEF);
    fill_word(18, 64'h0F1E2D3C4B5A6978);
    d0 = done_cnt_b;
    accept(1'b1, 1'b0, acc);
    // Byte 3 ('E' = 0x45) starts at acc+121; its 5th data bit (0) spans acc+141..144.
    repeat (142) @(negedge clk);
    vec++;
    if (busy_b !== 1'b1 || tx_b !== 1'b0) begin
      miss++;
      $display("FAIL mid-frame before reset: busy %b tx %b, expected 1 0", busy_b, tx_b);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    vec++;
    if (tx_b !== 1'b1 || busy_b !== 1'b0 || done_b !== 1'b0) begin
      miss++;
      $display("FAIL reset abort: tx %b busy %b done %b, expected 1 0 0", tx_b, busy_b, done_b);
    end
    bad = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (tx_b !== 1'b1 || busy_b !== 1'b0 || done_b !== 1'b0) bad = 1'b1;
    end
    vec++;
    if (bad || done_cnt_b != d0) begin
      miss++;
      $display("FAIL after abort: line activity %0d, done pulses %0d, expected 0 0", bad, done_cnt_b - d0);
    end
    accept(1'b1, 1'b0, acc);
    rx_frame(1'b1, 36, acc, 1'b0, "after-reset");
    repeat (5) @(negedge clk);
    vec++;
    if (done_cnt_b != d0 + 1) begin
      miss++;
      $display("FAIL after-reset done count: got %0d, expected 1", done_cnt_b - d0);
    end
  endtask

  task automatic test_start_held();
    int acc;
    int d0;
    prod_a = 64'hFEDCBA9876543210;
    fill_word(0, 64'hFEDCBA9876543210);
    d0 = done_cnt_a;
    accept(1'b0, 1'b1, acc);
    rx_frame(1'b0, 18, acc, 1'b0, "held-1");
    // Start still high in the done cycle: accepted on the next edge.
    rx_frame(1'b0, 18, cyc + 1, 1'b1, "held-2");
    repeat (10) @(negedge clk);
    vec++;
    if (done_cnt_a != d0 + 2 || busy_a !== 1'b0 || tx_a !== 1'b1) begin
      miss++;
      $display("FAIL held end: done pulses %0d busy %b tx %b, expected 2 0 1", done_cnt_a - d0, busy_a, tx_a);
    end
  endtask

  initial begin
    test_reset();
    test_frame_n1();
    test_frame_n2();
    test_snapshot();
    test_reset_mid();
    test_start_held();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
